ctrl_mc: RTL and testbench

// Parametrised multicycle control FSM for the SISC datapath; next generation of the fixed 7-state controller.

---
 rtl/ctrl_mc_if.sv | 36 +++
 rtl/ctrl_mc.sv | 135 +++++++++++++
 tb/tb_ctrl_mc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_mc_if.sv
// rtl/ctrl_mc_if.sv - IR/status inputs and datapath control outputs of the multicycle controller
interface ctrl_mc_if #(
    parameter int STAT_W = 4
);
    logic [3:0]        opcode;
    logic [STAT_W-1:0] mm;
    logic [STAT_W-1:0] stat;
    logic              mem_ack;
    logic              rf_we;
    logic [1:0]        alu_op;
    logic              wb_sel;
    logic              swp_sel;
    logic              br_sel;
    logic              pc_sel;
    logic              pc_write;
    logic              pc_rst;
    logic              ir_load;
    logic              dm_re;
    logic              dm_we;
    logic              halted;
    logic              timeout_err;

    // controller side
    modport master (
        input  opcode, mm, stat, mem_ack,
        output rf_we, alu_op, wb_sel, swp_sel, br_sel, pc_sel, pc_write,
               pc_rst, ir_load, dm_re, dm_we, halted, timeout_err
    );

    // datapath side
    modport slave (
        output opcode, mm, stat, mem_ack,
        input  rf_we, alu_op, wb_sel, swp_sel, br_sel, pc_sel, pc_write,
               pc_rst, ir_load, dm_re, dm_we, halted, timeout_err
    );
endinterface

// File: rtl/ctrl_mc.sv
// rtl/ctrl_mc.sv - multicycle SISC control FSM with memory handshake, timeout and HALT
module ctrl_mc #(
    parameter int STAT_W   = 4,
    parameter int AM_IMM   = 8,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic      clk,
    input  logic      rst_f,
    ctrl_mc_if.master bus
);
    typedef enum logic [3:0] {
        START0, START1, FETCH, DECODE, EXECUTE, MEM, WB1, WB2, HALT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    // opcode classes; 9..14 fall through every class and behave as NOOP
    logic is_lod, is_str, is_swp, is_alu, is_hlt;
    logic is_bra, is_brr, is_bne, is_bnr;
    logic is_mem, needs_exec, imm, cond, taken;
    logic [1:0] exec_alu_op;

    assign is_lod = (bus.opcode == 4'd1);
    assign is_str = (bus.opcode == 4'd2);
    assign is_swp = (bus.opcode == 4'd3);
    assign is_bra = (bus.opcode == 4'd4);
    assign is_brr = (bus.opcode == 4'd5);
    assign is_bne = (bus.opcode == 4'd6);
    assign is_bnr = (bus.opcode == 4'd7);
    assign is_alu = (bus.opcode == 4'd8);
    assign is_hlt = (bus.opcode == 4'd15);

    assign is_mem     = is_lod | is_str;
    assign needs_exec = is_mem | is_swp | is_alu;
    assign imm        = (bus.mm == STAT_W'(AM_IMM));
    assign cond       = |(bus.mm & bus.stat);
    assign taken      = ((is_bra | is_brr) & cond) | ((is_bne | is_bnr) & ~cond);

    // ALU control shared by EXECUTE, MEM and WB1 so address/result stay stable across phases
    assign exec_alu_op = is_alu ? {1'b0, imm} :
                         is_mem ? {1'b1, ~imm} : 2'b10;

    // state sequencing, memory wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= START1;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                START0:  state <= START1;
                START1:  state <= FETCH;
                FETCH:   state <= DECODE;
                DECODE: begin
                    if (is_hlt)          state <= HALT;
                    else if (needs_exec) state <= EXECUTE;
                    else                 state <= FETCH;
                end
                EXECUTE: begin
                    if (is_mem) begin
                        state    <= MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= WB1;
                    end
                end
                MEM: begin
                    // an ack on the final allowed cycle still completes normally
                    if (bus.mem_ack) begin
                        state <= is_lod ? WB1 : FETCH;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WB1:     state <= is_swp ? WB2 : FETCH;
                WB2:     state <= FETCH;
                HALT:    state <= HALT;
                default: state <= START1;
            endcase
        end
    end

    // Moore output decode; only the DECODE-cycle branch load looks at live status
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.alu_op   = 2'b10;
        bus.wb_sel   = 1'b0;
        bus.swp_sel  = 1'b0;
        bus.br_sel   = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.dm_re    = 1'b0;
        bus.dm_we    = 1'b0;
        bus.halted   = 1'b0;
        case (state)
            START0, START1: bus.pc_rst = 1'b1;
            FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
            end
            DECODE: begin
                bus.pc_sel   = 1'b1;
                bus.br_sel   = is_bra | is_bne;
                bus.pc_write = taken;
            end
            EXECUTE: bus.alu_op = exec_alu_op;
            MEM: begin
                bus.alu_op = exec_alu_op;
                bus.dm_re  = is_lod;
                bus.dm_we  = is_str;
            end
            WB1: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = is_lod;
                bus.alu_op = exec_alu_op;
            end
            WB2: begin
                bus.rf_we   = 1'b1;
                bus.swp_sel = 1'b1;
            end
            HALT:    bus.halted = 1'b1;
            default: bus.pc_rst = 1'b1;
        endcase
    end

    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_ctrl_mc.sv
// tb/tb_ctrl_mc.sv - scoreboard bench for ctrl_mc
module tb_ctrl_mc;
    localparam int S_START1 = 1, S_FETCH = 2, S_DECODE = 3, S_EXEC = 4;
    localparam int S_MEM = 5, S_WB1 = 6, S_WB2 = 7, S_HALT = 8;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    ctrl_mc_if #(.STAT_W(4)) bus ();

    ctrl_mc #(.STAT_W(4), .AM_IMM(8), .MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [13:0] obs;
    assign obs = {bus.rf_we, bus.alu_op, bus.wb_sel, bus.swp_sel, bus.br_sel, bus.pc_sel,
                  bus.pc_write, bus.pc_rst, bus.ir_load, bus.dm_re, bus.dm_we,
                  bus.halted, bus.timeout_err};

    typedef struct {
        string       tag;
        logic [13:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, expv);
    endtask

    // expected control vector for one cycle
    function automatic logic [13:0] model(input int st, input int op, input logic [3:0] m,
                                          input logic [3:0] s, input logic te);
        logic rf_we, wb_sel, swp_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load;
        logic dm_re, dm_we, halted;
        logic [1:0] alu, xalu;
        rf_we = 0; wb_sel = 0; swp_sel = 0; br_sel = 0; pc_sel = 0; pc_write = 0;
        pc_rst = 0; ir_load = 0; dm_re = 0; dm_we = 0; halted = 0; alu = 2'b10;
        if (op == 8)                xalu = (m == 4'd8) ? 2'b01 : 2'b00;
        else if (op == 1 || op == 2) xalu = (m == 4'd8) ? 2'b10 : 2'b11;
        else                        xalu = 2'b10;
        case (st)
            S_START1: pc_rst = 1;
            S_FETCH: begin ir_load = 1; pc_write = 1; end
            S_DECODE: begin
                pc_sel = 1;
                br_sel = (op == 4 || op == 6);
                if ((op == 4 || op == 5) && ((m & s) != 0)) pc_write = 1;
                if ((op == 6 || op == 7) && ((m & s) == 0)) pc_write = 1;
            end
            S_EXEC: alu = xalu;
            S_MEM: begin alu = xalu; dm_re = (op == 1); dm_we = (op == 2); end
            S_WB1: begin rf_we = 1; wb_sel = (op == 1); alu = xalu; end
            S_WB2: begin rf_we = 1; swp_sel = 1; end
            S_HALT: halted = 1;
            default: ;
        endcase
        return {rf_we, alu, wb_sel, swp_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load,
                dm_re, dm_we, halted, te};
    endfunction

    // compare each scoreboard entry against the outputs mid-cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.tag, 32'(obs), 32'(e.val));
        end
    end

    // one cycle: drive inputs, queue the expected vector, advance past the edge
    task automatic cyc(input string tag, input int st, input int op, input logic [3:0] m,
                       input logic [3:0] s, input logic ack, input logic te);
        exp_t e;
        bus.opcode  = 4'(op);
        bus.mm      = m;
        bus.stat    = s;
        bus.mem_ack = ack;
        e.tag = $sformatf("%s_op%0d_st%0d", tag, op, st);
        e.val = model(st, op, m, s, te);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_f = 1'b0;
        cyc({tag, "_rst"}, S_START1, 0, 4'd0, 4'd0, 1'b1, 1'b0);
        rst_f = 1'b1;
        cyc({tag, "_start1"}, S_START1, 0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // ack_at: MEM cycle index carrying mem_ack, negative for never
    task automatic run(input string tag, input int op, input logic [3:0] m,
                       input logic [3:0] s, input int ack_at);
        logic acked;
        acked = 1'b0;
        cyc(tag, S_FETCH, op, m, s, 1'b1, 1'b0);
        cyc(tag, S_DECODE, op, m, s, 1'b1, 1'b0);
        if (op == 15) begin
            for (int i = 0; i < 4; i++) cyc(tag, S_HALT, op, m, s, 1'b1, 1'b0);
        end else if (op == 1 || op == 2 || op == 3 || op == 8) begin
            cyc(tag, S_EXEC, op, m, s, 1'b1, 1'b0);
            if (op == 1 || op == 2) begin
                for (int i = 0; i < 15 && !acked; i++) begin
                    acked = (i == ack_at);
                    cyc(tag, S_MEM, op, m, s, acked, 1'b0);
                end
                if (!acked) begin
                    for (int i = 0; i < 3; i++) cyc(tag, S_HALT, op, m, s, 1'b1, 1'b1);
                end else if (op == 1) begin
                    cyc(tag, S_WB1, op, m, s, 1'b0, 1'b0);
                end
            end else begin
                cyc(tag, S_WB1, op, m, s, 1'b0, 1'b0);
                if (op == 3) cyc(tag, S_WB2, op, m, s, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        bus.opcode = 4'd0; bus.mm = 4'd0; bus.stat = 4'd0; bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");
        run("alu_reg", 8, 4'd0, 4'd0, -1);
        run("alu_imm", 8, 4'd8, 4'd5, -1);
        run("bra_t", 4, 4'b0010, 4'b0010, -1);
        run("bra_nt", 4, 4'b0010, 4'b0000, -1);
        run("bnr_t", 7, 4'b0001, 4'b0000, -1);
        run("bne_nt", 6, 4'b0001, 4'b0011, -1);
        run("brr_t", 5, 4'b0011, 4'b0001, -1);
        run("noop", 0, 4'hf, 4'hf, -1);
        run("unk9", 9, 4'hf, 4'hf, -1);
        run("unk14", 14, 4'h1, 4'h0, -1);
        run("lod_w3", 1, 4'd8, 4'd0, 3);
        run("lod_w0", 1, 4'd0, 4'd0, 0);
        run("str_w0", 2, 4'd0, 4'd0, 0);
        run("swp", 3, 4'd0, 4'd0, -1);
        run("str_last", 2, 4'd8, 4'd0, 14);
        run("str_to", 2, 4'd0, 4'd0, -1);
        do_reset("after_to");
        run("hlt", 15, 4'd0, 4'd0, -1);
        do_reset("after_hlt");

        // reset asserted in the middle of a memory wait
        cyc("mid", S_FETCH, 2, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc("mid", S_DECODE, 2, 4'd0, 4'd0, 1'b0, 1'b0);
        cyc("mid", S_EXEC, 2, 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("mid", S_MEM, 2, 4'd0, 4'd0, 1'b0, 1'b0);
        rst_f = 1'b0;
        #1;
        chk("mid_rst_vec", 32'(obs), 32'(model(S_START1, 0, 4'd0, 4'd0, 1'b0)));
        chk("mid_rst_dm_we", 32'(bus.dm_we), 32'd0);
        do_reset("mid");
        run("post_alu", 8, 4'd8, 4'd0, -1);

        @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
